// File: rtl/vraster_timing.sv
// Raster timing generator for the Vector-06C video path: pixel/line counters,
// sync and window decode, scrolled framebuffer addressing and the frame interrupt.
module vraster_timing #(
    parameter int H_TOTAL      = 768,
    parameter int H_ACT_START  = 128,
    parameter int H_ACT_LEN    = 512,
    parameter int H_SYNC_START = 664,
    parameter int H_SYNC_LEN   = 56,
    parameter int V_TOTAL      = 312,
    parameter int V_ACT_START  = 40,
    parameter int V_ACT_LEN    = 256,
    parameter int V_SYNC_START = 304,
    parameter int V_SYNC_LEN   = 4,
    parameter int V_INT_LINE   = 0,
    parameter int INT_TIMEOUT  = 4
) (
    input  logic       clk24,
    input  logic       resetn,
    input  logic       ce12,
    input  logic [7:0] scroll_in,
    input  logic       scroll_wr,
    input  logic       int_ack,
    output logic [9:0] hcount,
    output logic [8:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       border,
    output logic [7:0] row_addr,
    output logic [4:0] col_addr,
    output logic       frame_start,
    output logic       int_req
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HA_LO  = 10'(H_ACT_START);
    localparam logic [9:0] HA_HI  = 10'(H_ACT_START + H_ACT_LEN);
    localparam logic [9:0] HS_LO  = 10'(H_SYNC_START);
    localparam logic [9:0] HS_HI  = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] VA_LO  = 9'(V_ACT_START);
    localparam logic [8:0] VA_HI  = 9'(V_ACT_START + V_ACT_LEN);
    localparam logic [8:0] VS_LO  = 9'(V_SYNC_START);
    localparam logic [8:0] VS_HI  = 9'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [8:0] V_INT  = 9'(V_INT_LINE);
    localparam logic [7:0] VA_LO8 = 8'(V_ACT_START);
    localparam logic [7:0] ROW_RST = 8'(256 - V_ACT_START);
    localparam int         TW     = $clog2(INT_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(INT_TIMEOUT - 1);

    typedef enum logic {IDLE, REQ} int_state_t;

    logic       h_wrap, f_wrap, raise;
    logic [9:0] h_nxt;
    logic [8:0] v_nxt, v_sel;
    logic       hs_nxt, vs_nxt, act_nxt;
    logic [4:0] col_nxt;
    logic [7:0] shadow, roll, roll_eff;
    int_state_t state;
    logic [TW-1:0] timer;

    // Decode is done on the next counter values so the registered outputs
    // line up with the hcount/vcount they describe.
    always_comb begin
        h_wrap  = (hcount == H_LAST);
        f_wrap  = h_wrap && (vcount == V_LAST);
        h_nxt   = h_wrap ? 10'd0 : hcount + 10'd1;
        v_nxt   = h_wrap ? (f_wrap ? 9'd0 : vcount + 9'd1) : vcount;
        hs_nxt  = (h_nxt >= HS_LO) && (h_nxt < HS_HI);
        vs_nxt  = (v_nxt >= VS_LO) && (v_nxt < VS_HI);
        act_nxt = (h_nxt >= HA_LO) && (h_nxt < HA_HI) && (v_nxt >= VA_LO) && (v_nxt < VA_HI);
        col_nxt = act_nxt ? 5'((h_nxt - HA_LO) >> 4) : 5'd0;
        raise   = ce12 && h_wrap && (v_nxt == V_INT);
        // A write coincident with the frame_start cycle lands in the new frame.
        roll_eff = frame_start ? (scroll_wr ? scroll_in : shadow) : roll;
        v_sel    = ce12 ? v_nxt : vcount;
    end

    always_ff @(posedge clk24) begin
        if (!resetn) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            active      <= 1'b0;
            border      <= 1'b0;
            col_addr    <= '0;
            row_addr    <= ROW_RST;
            frame_start <= 1'b0;
            shadow      <= '0;
            roll        <= '0;
        end else begin
            frame_start <= ce12 && f_wrap;
            if (scroll_wr)
                shadow <= scroll_in;
            roll <= roll_eff;
            // Row is also refreshed on the frame_start cycle so (0,0) sees the new roll.
            if (ce12 || frame_start)
                row_addr <= 8'(v_sel) - VA_LO8 + roll_eff;
            if (ce12) begin
                hcount   <= h_nxt;
                vcount   <= v_nxt;
                hsync    <= hs_nxt;
                vsync    <= vs_nxt;
                active   <= act_nxt;
                border   <= !act_nxt && !hs_nxt && !vs_nxt;
                col_addr <= col_nxt;
            end
        end
    end

    // Frame interrupt: raised once per frame, cleared by ack or after INT_TIMEOUT lines.
    always_ff @(posedge clk24) begin
        if (!resetn) begin
            state   <= IDLE;
            int_req <= 1'b0;
            timer   <= '0;
        end else if (raise) begin
            state   <= REQ;
            int_req <= 1'b1;
            timer   <= '0;
        end else if (state == REQ) begin
            if (int_ack) begin
                state   <= IDLE;
                int_req <= 1'b0;
            end else if (ce12 && h_wrap) begin
                if (timer == T_LAST) begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vraster_timing.sv
// Scoreboard bench for vraster_timing with a reduced raster (48x40) so whole
// frames fit in a short run; expectations are queued by stimulus, checked by a monitor.
module tb_vraster_timing;

    localparam int HT = 48, HAS = 8, HAL = 32, HSS = 41, HSL = 4;
    localparam int VT = 40, VAS = 8, VAL = 24, VSS = 34, VSL = 3;
    localparam int F  = HT * VT;

    logic       clk24 = 1'b0;
    logic       resetn, ce12, scroll_wr, int_ack;
    logic [7:0] scroll_in;
    logic [9:0] hcount;
    logic [8:0] vcount;
    logic       hsync, vsync, active, border, frame_start, int_req;
    logic [7:0] row_addr;
    logic [4:0] col_addr;

    vraster_timing #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT_LEN(HAL), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT_LEN(VAL), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .V_INT_LINE(0), .INT_TIMEOUT(4)
    ) dut (
        .clk24(clk24), .resetn(resetn), .ce12(ce12), .scroll_in(scroll_in),
        .scroll_wr(scroll_wr), .int_ack(int_ack), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .active(active), .border(border),
        .row_addr(row_addr), .col_addr(col_addr), .frame_start(frame_start), .int_req(int_req)
    );

    always #10 clk24 = ~clk24;

    int cyc = 0;
    always @(posedge clk24) cyc <= cyc + 1;

    typedef enum int {S_H, S_V, S_ROW, S_COL, S_HS, S_VS, S_ACT, S_BOR, S_FS, S_INT} sel_t;
    typedef struct {
        int    cyc;
        sel_t  sel;
        int    val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   fs_q[$];
    int   checks = 0, errors = 0;
    int   p = 0;

    function automatic int dut_val(sel_t s);
        case (s)
            S_H:   return int'(hcount);
            S_V:   return int'(vcount);
            S_ROW: return int'(row_addr);
            S_COL: return int'(col_addr);
            S_HS:  return int'(hsync);
            S_VS:  return int'(vsync);
            S_ACT: return int'(active);
            S_BOR: return int'(border);
            S_FS:  return int'(frame_start);
            default: return int'(int_req);
        endcase
    endfunction

    task automatic expect1(sel_t s, int v, string nm);
        exp_t e;
        e.cyc = cyc; e.sel = s; e.val = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compares queued expectations and accounts for every frame_start pulse.
    initial begin
        exp_t e;
        int   got;
        forever begin
            @(negedge clk24);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                got = dut_val(e.sel);
                checks++;
                if (got != e.val || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d, queued %0d)",
                             e.name, got, e.val, cyc, e.cyc);
                end
            end
            if (frame_start) begin
                checks++;
                if (fs_q.size() > 0 && fs_q[0] == cyc) begin
                    void'(fs_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL frame_start_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end
            end
            while (fs_q.size() > 0 && fs_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL frame_start_missed: got 0 expected 1 at cycle %0d", fs_q[0]);
                void'(fs_q.pop_front());
            end
        end
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation still running at cycle %0d, expected done", cyc);
        $fatal(1, "watchdog");
    end

    task automatic pix(int n);
        repeat (n) begin
            if ((p + 1) % F == 0) fs_q.push_back(cyc + 1);
            ce12 = 1'b1;
            @(negedge clk24);
            p++;
            ce12 = 1'b0;
            @(negedge clk24);
        end
    endtask

    task automatic goto(int t);
        pix(t - p);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        @(negedge clk24);
        int_ack = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; ce12 = 1'b0; scroll_wr = 1'b0; scroll_in = 8'h00; int_ack = 1'b0;
        @(negedge clk24);
        repeat (2) begin
            ce12 = 1'b1; @(negedge clk24);
            ce12 = 1'b0; @(negedge clk24);
        end
        expect1(S_H, 0, "rst_h");      expect1(S_V, 0, "rst_v");
        expect1(S_ROW, 8'hF8, "rst_row"); expect1(S_COL, 0, "rst_col");
        expect1(S_HS, 0, "rst_hs");    expect1(S_VS, 0, "rst_vs");
        expect1(S_ACT, 0, "rst_act");  expect1(S_BOR, 0, "rst_bor");
        expect1(S_FS, 0, "rst_fs");    expect1(S_INT, 0, "rst_int");
        resetn = 1'b1; p = 0;

        // Frame 1: window and sync boundaries.
        pix(1);
        expect1(S_H, 1, "h1"); expect1(S_BOR, 1, "bor_h1"); expect1(S_INT, 0, "no_int_after_rst");
        goto(8*HT + 7);
        expect1(S_ACT, 0, "act_before_h8"); expect1(S_BOR, 1, "bor_h7");
        pix(1);
        expect1(S_ACT, 1, "act_first"); expect1(S_BOR, 0, "bor_act");
        expect1(S_ROW, 0, "row_v8"); expect1(S_COL, 0, "col_h8");
        goto(8*HT + 24); expect1(S_COL, 1, "col_h24");
        goto(8*HT + 39); expect1(S_ACT, 1, "act_last"); expect1(S_COL, 1, "col_h39");
        pix(1); expect1(S_ACT, 0, "act_h40"); expect1(S_COL, 0, "col_h40"); expect1(S_BOR, 1, "bor_h40");
        pix(1); expect1(S_HS, 1, "hs_first"); expect1(S_BOR, 0, "bor_hs");
        goto(8*HT + 44); expect1(S_HS, 1, "hs_last");
        pix(1); expect1(S_HS, 0, "hs_end"); expect1(S_H, 45, "h45");

        // Freeze: ce12 held low.
        repeat (100) @(negedge clk24);
        expect1(S_H, 45, "frz_h"); expect1(S_V, 8, "frz_v"); expect1(S_HS, 0, "frz_hs");
        expect1(S_BOR, 1, "frz_bor"); expect1(S_ACT, 0, "frz_act"); expect1(S_ROW, 0, "frz_row");

        // Mid-frame scroll write only applies next frame.
        goto(20*HT); expect1(S_V, 20, "v20"); expect1(S_ROW, 12, "row_v20");
        scroll_in = 8'hF0; scroll_wr = 1'b1; @(negedge clk24); scroll_wr = 1'b0;
        expect1(S_ROW, 12, "row_after_wr");
        goto(30*HT); expect1(S_ROW, 22, "row_v30_old_roll");

        // Frame 2: new roll, interrupt timeout, vertical boundaries.
        goto(F);
        expect1(S_H, 0, "f2_h"); expect1(S_V, 0, "f2_v"); expect1(S_INT, 1, "int_raise");
        expect1(S_ROW, 8'hE8, "row_f2_v0"); expect1(S_FS, 0, "fs_one_cycle");
        goto(F + 4*HT - 1); expect1(S_INT, 1, "int_v3");
        pix(1); expect1(S_V, 4, "v4"); expect1(S_INT, 0, "int_timeout");
        goto(F + 8*HT);  expect1(S_ROW, 8'hF0, "row_v8_roll");
        goto(F + 24*HT); expect1(S_ROW, 8'h00, "row_wrap");
        goto(F + 31*HT + 8); expect1(S_ACT, 1, "act_last_line");
        goto(F + 32*HT + 8); expect1(S_ACT, 0, "act_after_last"); expect1(S_BOR, 1, "bor_v32");
        goto(F + 34*HT - 1); expect1(S_VS, 0, "vs_before");
        pix(1); expect1(S_VS, 1, "vs_first"); expect1(S_BOR, 0, "bor_vs");
        goto(F + 37*HT - 1); expect1(S_VS, 1, "vs_last");
        pix(1); expect1(S_VS, 0, "vs_end"); expect1(S_V, 37, "v37");

        // Frame 3: acknowledge, then ack while idle.
        goto(2*F); expect1(S_INT, 1, "int_f3");
        goto(2*F + HT); expect1(S_INT, 1, "int_v1");
        pulse_ack(); expect1(S_INT, 0, "int_acked");
        goto(2*F + 5*HT); expect1(S_INT, 0, "int_stays_low");
        pulse_ack(); expect1(S_INT, 0, "ack_idle");
        goto(2*F + 20*HT + 5); expect1(S_H, 5, "pre_rst_h");

        // Single-cycle reset mid-frame.
        resetn = 1'b0; @(negedge clk24); resetn = 1'b1; p = 0;
        expect1(S_H, 0, "mrst_h"); expect1(S_V, 0, "mrst_v"); expect1(S_INT, 0, "mrst_int");
        expect1(S_ROW, 8'hF8, "mrst_row"); expect1(S_FS, 0, "mrst_fs");
        pix(1); expect1(S_INT, 0, "mrst_no_int");
        goto(8*HT); expect1(S_ROW, 0, "mrst_roll0");

        // Scroll write coincident with frame_start.
        goto(F - 1);
        fs_q.push_back(cyc + 1);
        ce12 = 1'b1; @(negedge clk24); p++;
        ce12 = 1'b0; scroll_in = 8'h10; scroll_wr = 1'b1; @(negedge clk24); scroll_wr = 1'b0;
        expect1(S_H, 0, "co_h"); expect1(S_ROW, 8'h08, "co_row_v0"); expect1(S_INT, 1, "co_int");
        goto(F + 8*HT); expect1(S_ROW, 8'h10, "co_row_v8");

        repeat (4) @(negedge clk24);
        checks++;
        if (fs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got %0d/%0d pending expected 0/0", fs_q.size(), exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
